// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared definitions for the instruction-fetch stage: the NOP
//                encoding and the fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // driving a fetch request
        S_WAIT = 2'd1,   // request accepted, awaiting response
        S_HOLD = 2'd2,   // response parked while decode is stalled
        S_DROP = 2'd3    // redirected while in flight, discard next response
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Issues one imem read per PC value
//                (at most one outstanding), owns the IF/ID register and a
//                1-entry hold buffer for decode stalls, and drives pause back
//                to the PC register. Redirects discard in-flight fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          XLEN = 32,
    parameter logic [31:0] NOP  = NOP_INST
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            stall,
    output logic            pause,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst
);

    fetch_state_t    state;
    fetch_state_t    state_next;

    logic [XLEN-1:0] req_pc;
    logic            hold_valid;
    logic [31:0]     hold_data;
    logic [XLEN-1:0] hold_pc;

    logic            accept;
    logic            deliver;
    logic            park;
    logic [XLEN-1:0] deliver_pc;
    logic [31:0]     deliver_inst;

    // Request interface: only in REQ, and never while reset is held.
    assign imem_req_valid = (state == S_REQ) && !reset;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // PC advances once per delivered instruction; a redirect always releases it.
    assign pause = reset || !(deliver || flush);

    // Next-state logic plus deliver/park decisions.
    always_comb begin
        state_next   = state;
        deliver      = 1'b0;
        park         = 1'b0;
        deliver_pc   = req_pc;
        deliver_inst = imem_rsp_data;
        case (state)
            S_REQ: begin
                if (accept)
                    state_next = flush ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush) begin
                        state_next = S_REQ;
                    end else if (stall) begin
                        park       = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        deliver    = 1'b1;
                        state_next = S_REQ;
                    end
                end else if (flush) begin
                    state_next = S_DROP;
                end
            end
            S_HOLD: begin
                deliver_pc   = hold_pc;
                deliver_inst = hold_data;
                if (flush) begin
                    state_next = S_REQ;
                end else if (!stall) begin
                    deliver    = hold_valid;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid)
                    state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_REQ;
        else       state <= state_next;
    end

    // Capture the PC of the accepted request so the response can be tagged.
    always_ff @(posedge clock) begin
        if (reset)       req_pc <= '0;
        else if (accept) req_pc <= pc;
    end

    // One-entry hold buffer: filled on a stalled response, emptied on
    // delivery or redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= NOP;
            hold_pc    <= '0;
        end else if (park) begin
            hold_valid <= 1'b1;
            hold_data  <= imem_rsp_data;
            hold_pc    <= req_pc;
        end else if (state == S_HOLD && (flush || !stall)) begin
            hold_valid <= 1'b0;
        end
    end

    // IF/ID register: reset > flush > stall > deliver > bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= NOP;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_inst  <= NOP;
        end else if (stall) begin
            id_valid <= id_valid;
        end else if (deliver) begin
            id_valid <= 1'b1;
            id_pc    <= deliver_pc;
            id_inst  <= deliver_inst;
        end else begin
            id_valid <= 1'b0;
            id_inst  <= NOP;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed self-checking bench for if_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic        pause;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int total  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    if_stage dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .flush          (flush),
        .stall          (stall),
        .pause          (pause),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; pc = '0; flush = 0; stall = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin failed++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        total++; if (pause !== 1'b1) begin failed++; $display("FAIL rst_pause got %b exp 1", pause); end
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b0) begin failed++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
        total++; if (id_pc !== 32'h0) begin failed++; $display("FAIL rst_id_pc got %h exp 0", id_pc); end
        total++; if (id_inst !== NOPI) begin failed++; $display("FAIL rst_id_inst got %h exp %h", id_inst, NOPI); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        pc = 32'h0; imem_req_ready = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b1) begin failed++; $display("FAIL f_req_valid got %b exp 1", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h0) begin failed++; $display("FAIL f_req_addr got %h exp 0", imem_req_addr); end
        total++; if (pause !== 1'b1) begin failed++; $display("FAIL f_pause_req got %b exp 1", pause); end
        @(negedge clock);
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0050_0093;
        #1;
        total++; if (pause !== 1'b0) begin failed++; $display("FAIL f_pause_deliver got %b exp 0", pause); end
        total++; if (imem_req_valid !== 1'b0) begin failed++; $display("FAIL f_req_valid_wait got %b exp 0", imem_req_valid); end
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b1) begin failed++; $display("FAIL f_id_valid got %b exp 1", id_valid); end
        total++; if (id_pc !== 32'h0) begin failed++; $display("FAIL f_id_pc got %h exp 0", id_pc); end
        total++; if (id_inst !== 32'h0050_0093) begin failed++; $display("FAIL f_id_inst got %h exp 00500093", id_inst); end
        @(negedge clock);
        imem_rsp_valid = 0; pc = 32'h4;
        #1;
        total++; if (pause !== 1'b1) begin failed++; $display("FAIL f_pause_after got %b exp 1", pause); end
    endtask

    task automatic test_stall_hold();
        imem_req_ready = 1'b1;
        @(posedge clock);          // accepted; also bubbles IF/ID
        @(negedge clock);
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0010_0113; stall = 1;
        #1;
        total++; if (pause !== 1'b1) begin failed++; $display("FAIL s_pause_park got %b exp 1", pause); end
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b0) begin failed++; $display("FAIL s_id_valid_hold got %b exp 0", id_valid); end
        total++; if (id_pc !== 32'h0) begin failed++; $display("FAIL s_id_pc_hold got %h exp 0", id_pc); end
        total++; if (id_inst !== NOPI) begin failed++; $display("FAIL s_id_inst_hold got %h exp %h", id_inst, NOPI); end
        @(negedge clock);
        imem_rsp_valid = 0;
        #1;
        total++; if (pause !== 1'b1) begin failed++; $display("FAIL s_pause_hold got %b exp 1", pause); end
        total++; if (imem_req_valid !== 1'b0) begin failed++; $display("FAIL s_req_valid_hold got %b exp 0", imem_req_valid); end
        @(negedge clock);
        stall = 0;
        #1;
        total++; if (pause !== 1'b0) begin failed++; $display("FAIL s_pause_release got %b exp 0", pause); end
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b1) begin failed++; $display("FAIL s_id_valid got %b exp 1", id_valid); end
        total++; if (id_pc !== 32'h4) begin failed++; $display("FAIL s_id_pc got %h exp 4", id_pc); end
        total++; if (id_inst !== 32'h0010_0113) begin failed++; $display("FAIL s_id_inst got %h exp 00100113", id_inst); end
    endtask

    task automatic test_flush_wait();
        @(negedge clock);
        pc = 32'h8; imem_req_ready = 1'b1;
        @(posedge clock);          // accepted -> WAIT
        @(negedge clock);
        imem_req_ready = 0; flush = 1; pc = 32'h40;
        #1;
        total++; if (pause !== 1'b0) begin failed++; $display("FAIL fw_pause_flush got %b exp 0", pause); end
        @(posedge clock);          // -> DROP
        @(negedge clock);
        flush = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hdead_beef;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin failed++; $display("FAIL fw_req_valid_drop got %b exp 0", imem_req_valid); end
        total++; if (pause !== 1'b1) begin failed++; $display("FAIL fw_pause_drop got %b exp 1", pause); end
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b0) begin failed++; $display("FAIL fw_id_valid got %b exp 0", id_valid); end
        total++; if (id_inst !== NOPI) begin failed++; $display("FAIL fw_id_inst got %h exp %h", id_inst, NOPI); end
        @(negedge clock);
        imem_rsp_valid = 0;
        #1;
        total++; if (imem_req_valid !== 1'b1) begin failed++; $display("FAIL fw_req_valid_new got %b exp 1", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h40) begin failed++; $display("FAIL fw_req_addr_new got %h exp 40", imem_req_addr); end
    endtask

    task automatic test_flush_stall();
        imem_req_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0020_0193;
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b1) begin failed++; $display("FAIL fs_pre_valid got %b exp 1", id_valid); end
        total++; if (id_pc !== 32'h40) begin failed++; $display("FAIL fs_pre_pc got %h exp 40", id_pc); end
        @(negedge clock);
        imem_rsp_valid = 0; flush = 1; stall = 1;
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b0) begin failed++; $display("FAIL fs_id_valid got %b exp 0", id_valid); end
        total++; if (id_inst !== NOPI) begin failed++; $display("FAIL fs_id_inst got %h exp %h", id_inst, NOPI); end
        @(negedge clock);
        flush = 0; stall = 0;
    endtask

    task automatic test_ready_low_then_reset_in_hold();
        pc = 32'h44; imem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (imem_req_valid !== 1'b1) begin failed++; $display("FAIL rl_req_valid[%0d] got %b exp 1", i, imem_req_valid); end
            total++; if (imem_req_addr !== 32'h44) begin failed++; $display("FAIL rl_req_addr[%0d] got %h exp 44", i, imem_req_addr); end
            total++; if (pause !== 1'b1) begin failed++; $display("FAIL rl_pause[%0d] got %b exp 1", i, pause); end
            @(negedge clock);
        end
        imem_req_ready = 1;
        @(negedge clock);
        imem_req_ready = 0;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin failed++; $display("FAIL rl_wait_req_valid got %b exp 0", imem_req_valid); end
        // Park a response in HOLD, then reset.
        imem_rsp_valid = 1; imem_rsp_data = 32'h0030_0213; stall = 1;
        @(negedge clock);
        imem_rsp_valid = 0; reset = 1;
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b0) begin failed++; $display("FAIL rh_id_valid got %b exp 0", id_valid); end
        total++; if (id_pc !== 32'h0) begin failed++; $display("FAIL rh_id_pc got %h exp 0", id_pc); end
        total++; if (id_inst !== NOPI) begin failed++; $display("FAIL rh_id_inst got %h exp %h", id_inst, NOPI); end
        total++; if (pause !== 1'b1) begin failed++; $display("FAIL rh_pause got %b exp 1", pause); end
        @(negedge clock);
        reset = 0; stall = 0;
        #1;
        total++; if (imem_req_valid !== 1'b1) begin failed++; $display("FAIL rh_req_valid got %b exp 1", imem_req_valid); end
        total++; if (pause !== 1'b1) begin failed++; $display("FAIL rh_pause_after got %b exp 1", pause); end
        @(posedge clock); #1;
        total++; if (id_valid !== 1'b0) begin failed++; $display("FAIL rh_no_deliver got %b exp 0", id_valid); end
    endtask

    initial begin
        reset = 1; pc = '0; flush = 0; stall = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        test_reset();
        test_fetch();
        test_stall_hold();
        test_flush_wait();
        test_flush_stall();
        test_ready_low_then_reset_in_hold();
        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
`default_nettype wire
